mips16_mc_control: RTL and testbench

//  Multicycle main control FSM for the mips16 datapath; sits directly upstream of ALU control.

---
 rtl/mips16_pkg.sv | 58 +++++
 rtl/mips16_mc_control.sv | 181 ++++++++++++++++++
 tb/tb_mips16_mc_control.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips16_pkg.sv
// Shared encodings for the mips16 multicycle control path: opcodes, datapath
// mux selects, ALUOp codes, control-FSM states and the bundled control word.
package mips16_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LI   = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b101,
    ALU_FUNC = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_REGA = 2'b11} pc_src_e;
  typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {MR_ALUOUT = 2'b00, MR_MDR = 2'b01, MR_PC = 2'b10} mem_to_reg_e;
  typedef enum logic [1:0] {SA_PC = 2'b00, SA_REGA = 2'b01, SA_ZERO = 2'b10} src_a_e;
  typedef enum logic [1:0] {SB_REGB = 2'b00, SB_ONE = 2'b01, SB_SEXT = 2'b10, SB_ZEXT = 2'b11} src_b_e;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_JAL
  } state_e;

  typedef struct packed {
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    pc_src_e     pc_src;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
    src_a_e      alu_src_a;
    src_b_e      alu_src_b;
    alu_op_e     alu_op;
    logic        instr_done;
    logic        illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips16_mc_control.sv
// Multicycle main control FSM for the mips16 datapath: sequences each
// instruction, drives datapath enables/selects and counts retired instructions.
module mips16_mc_control
  import mips16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_t            ctl;

  always_comb begin
    // NOTE: default first so every path assigns state_d; no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:                                  state_d = (func == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LI: state_d = S_EXEC_I;
          OP_LW, OP_SW:                          state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                        state_d = S_BRANCH;
          OP_J:                                  state_d = S_JUMP;
          OP_JAL:                                state_d = S_JAL;
          default:                               state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JR, S_JAL: state_d = S_FETCH;
      default:    state_d = S_RESET;
    endcase
  end

  // NOTE: outputs are decoded combinationally from state so that rst can squash
  // any write enable in the very cycle it is asserted.
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SB_ONE;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b  = SB_SEXT;
        ctl.illegal_op = !(opcode inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                                          OP_ANDI, OP_ORI, OP_LI, OP_LW, OP_SW});
      end
      S_EXEC_R: begin
        ctl.alu_src_a = SA_REGA;
        ctl.alu_op    = ALU_FUNC;
      end
      S_EXEC_I: begin
        case (opcode)
          OP_ADDI: begin ctl.alu_src_a = SA_REGA; ctl.alu_src_b = SB_SEXT; ctl.alu_op = ALU_ADD; end
          OP_SLTI: begin ctl.alu_src_a = SA_REGA; ctl.alu_src_b = SB_SEXT; ctl.alu_op = ALU_SLT; end
          OP_ANDI: begin ctl.alu_src_a = SA_REGA; ctl.alu_src_b = SB_ZEXT; ctl.alu_op = ALU_AND; end
          OP_ORI:  begin ctl.alu_src_a = SA_REGA; ctl.alu_src_b = SB_ZEXT; ctl.alu_op = ALU_OR;  end
          default: begin ctl.alu_src_a = SA_ZERO; ctl.alu_src_b = SB_SEXT; ctl.alu_op = ALU_ADD; end
        endcase
      end
      S_WB_R: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = RD_RD;
        ctl.instr_done = 1'b1;
      end
      S_WB_I: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = SA_REGA;
        ctl.alu_src_b = SB_SEXT;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = MR_MDR;
        ctl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write  = 1'b1;
        ctl.i_or_d     = 1'b1;
        ctl.instr_done = mem_ready;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = SA_REGA;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_src        = PC_ALUOUT;
        ctl.branch_ne     = (opcode == OP_BNE);
        ctl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_src     = PC_JUMP;
        ctl.instr_done = 1'b1;
      end
      S_JR: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_src     = PC_REGA;
        ctl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_src     = PC_JUMP;
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = RD_RA;
        ctl.mem_to_reg = MR_PC;
        ctl.instr_done = 1'b1;
      end
      default: ctl = '0;
    endcase
    if (rst) ctl = '0;
  end

  assign count_d = count_q + {{(CNT_W-1){1'b0}}, ctl.instr_done};

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign branch_ne     = ctl.branch_ne;
  assign pc_src        = ctl.pc_src;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign reg_write     = ctl.reg_write;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign instr_done    = ctl.instr_done;
  assign illegal_op    = ctl.illegal_op;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_mips16_mc_control.sv
// Bench for mips16_mc_control: each instruction is expanded by a reference model
// into its expected per-cycle control words, then checked cycle by cycle.
module tb_mips16_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src;
    logic       i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done, illegal_op;
  } ctl_t;

  typedef struct {
    ctl_t c;
    logic fixed;
    logic rdy;
  } step_t;

  logic pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic instr_done, illegal_op;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b;
  logic [2:0] alu_op;
  logic [15:0] instr_count;

  logic w2_pc_write, w2_pc_write_cond, w2_branch_ne, w2_i_or_d, w2_mem_read, w2_mem_write;
  logic w2_ir_write, w2_reg_write, w2_instr_done, w2_illegal_op;
  logic [1:0] w2_pc_src, w2_reg_dst, w2_mem_to_reg, w2_alu_src_a, w2_alu_src_b;
  logic [2:0] w2_alu_op;
  logic [1:0] w2_instr_count;

  ctl_t ctl1, ctl2;
  assign ctl1 = {pc_write, pc_write_cond, branch_ne, pc_src, i_or_d, mem_read, mem_write, ir_write,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};
  assign ctl2 = {w2_pc_write, w2_pc_write_cond, w2_branch_ne, w2_pc_src, w2_i_or_d, w2_mem_read,
                 w2_mem_write, w2_ir_write, w2_reg_write, w2_reg_dst, w2_mem_to_reg, w2_alu_src_a,
                 w2_alu_src_b, w2_alu_op, w2_instr_done, w2_illegal_op};

  mips16_mc_control #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  mips16_mc_control #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(w2_pc_write), .pc_write_cond(w2_pc_write_cond), .branch_ne(w2_branch_ne),
    .pc_src(w2_pc_src), .i_or_d(w2_i_or_d), .mem_read(w2_mem_read), .mem_write(w2_mem_write),
    .ir_write(w2_ir_write), .reg_write(w2_reg_write), .reg_dst(w2_reg_dst),
    .mem_to_reg(w2_mem_to_reg), .alu_src_a(w2_alu_src_a), .alu_src_b(w2_alu_src_b),
    .alu_op(w2_alu_op), .instr_done(w2_instr_done), .illegal_op(w2_illegal_op),
    .instr_count(w2_instr_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cnt_model = 0;
  step_t       q[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f,
                      6'h23, 6'h2b};
  endfunction

  function automatic ctl_t alu(logic [1:0] a, logic [1:0] b, logic [2:0] op);
    ctl_t c = '0;
    c.alu_src_a = a;
    c.alu_src_b = b;
    c.alu_op    = op;
    return c;
  endfunction

  task automatic add_step(ctl_t c, logic fixed, logic rdy);
    step_t s;
    s.c = c;
    s.fixed = fixed;
    s.rdy = rdy;
    q.push_back(s);
  endtask

  // Reference model: expected control word for every cycle of one instruction,
  // with fs fetch stalls and ms data-memory stalls.
  task automatic build(logic [5:0] op, logic [5:0] fn, int fs, int ms);
    ctl_t c;
    q.delete();
    c = alu(2'd0, 2'd1, 3'd0);
    c.mem_read = 1'b1;
    repeat (fs) add_step(c, 1'b1, 1'b0);
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    add_step(c, 1'b1, 1'b1);
    c = alu(2'd0, 2'd2, 3'd0);
    c.illegal_op = !is_legal(op);
    add_step(c, 1'b0, 1'b0);
    if (!is_legal(op)) return;
    c = '0;
    case (op)
      6'h00: begin
        if (fn == 6'h08) begin
          c.pc_write = 1'b1; c.pc_src = 2'd3;
        end else begin
          add_step(alu(2'd1, 2'd0, 3'd6), 1'b0, 1'b0);
          c.reg_write = 1'b1; c.reg_dst = 2'd1;
        end
      end
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f: begin
        case (op)
          6'h08:   add_step(alu(2'd1, 2'd2, 3'd0), 1'b0, 1'b0);
          6'h0a:   add_step(alu(2'd1, 2'd2, 3'd5), 1'b0, 1'b0);
          6'h0c:   add_step(alu(2'd1, 2'd3, 3'd2), 1'b0, 1'b0);
          6'h0d:   add_step(alu(2'd1, 2'd3, 3'd3), 1'b0, 1'b0);
          default: add_step(alu(2'd2, 2'd2, 3'd0), 1'b0, 1'b0);
        endcase
        c.reg_write = 1'b1;
      end
      6'h23: begin
        add_step(alu(2'd1, 2'd2, 3'd0), 1'b0, 1'b0);
        c.mem_read = 1'b1; c.i_or_d = 1'b1;
        repeat (ms) add_step(c, 1'b1, 1'b0);
        add_step(c, 1'b1, 1'b1);
        c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = 2'd1;
      end
      6'h2b: begin
        add_step(alu(2'd1, 2'd2, 3'd0), 1'b0, 1'b0);
        c.mem_write = 1'b1; c.i_or_d = 1'b1;
        repeat (ms) add_step(c, 1'b1, 1'b0);
        c.instr_done = 1'b1;
        add_step(c, 1'b1, 1'b1);
        return;
      end
      6'h04, 6'h05: begin
        c = alu(2'd1, 2'd0, 3'd1);
        c.pc_write_cond = 1'b1; c.pc_src = 2'd1; c.branch_ne = (op == 6'h05);
      end
      6'h02: begin
        c.pc_write = 1'b1; c.pc_src = 2'd2;
      end
      default: begin
        c.pc_write = 1'b1; c.pc_src = 2'd2;
        c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
      end
    endcase
    c.instr_done = 1'b1;
    add_step(c, 1'b0, 1'b1);
  endtask

  task automatic run(int limit, string tag);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      @(negedge clk);
      mem_ready = q[i].fixed ? q[i].rdy : 1'($urandom);
      #1;
      check($sformatf("%s_c%0d", tag, i), 32'(ctl1), 32'(q[i].c));
      check($sformatf("%s_c%0d_w2", tag, i), 32'(ctl2), 32'(q[i].c));
      if (q[i].c.instr_done) cnt_model++;
      @(posedge clk);
    end
  endtask

  task automatic check_counts(string tag);
    #1;
    check({tag, "_count"}, 32'(instr_count), cnt_model & 32'hFFFF);
    check({tag, "_count_w2"}, 32'(w2_instr_count), cnt_model % 4);
  endtask

  task automatic do_instr(logic [5:0] op, logic [5:0] fn, int fs, int ms, string tag);
    opcode = op;
    func = fn;
    build(op, fn, fs, ms);
    run(1000, tag);
    check_counts(tag);
  endtask

  task automatic reset_pulse(string tag);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check({tag, "_rst_outs"}, 32'(ctl1), 32'd0);
    check({tag, "_rst_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_rst_done"}, 32'(instr_done), 32'd0);
    @(posedge clk);
    cnt_model = 0;
    check_counts({tag, "_rst"});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_reset_state"}, 32'(ctl1), 32'd0);
  endtask

  initial begin
    logic [5:0] legal_ops[12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c,
                                  6'h0d, 6'h0f, 6'h23, 6'h2b};
    logic [5:0] op, fn;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_outs", 32'(ctl1), 32'd0);
      check("reset_count", 32'(instr_count), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", 32'(ctl1), 32'd0);

    do_instr(6'h00, 6'h20, 0, 0, "add");
    do_instr(6'h23, 6'h00, 0, 3, "lw_stall");
    do_instr(6'h04, 6'h00, 0, 0, "beq");
    do_instr(6'h05, 6'h00, 0, 0, "bne");
    do_instr(6'h0c, 6'h00, 0, 0, "andi");
    do_instr(6'h0a, 6'h00, 0, 0, "slti");
    do_instr(6'h0f, 6'h00, 0, 0, "li");
    do_instr(6'h3f, 6'h00, 0, 0, "illegal");
    do_instr(6'h03, 6'h00, 0, 0, "jal");
    do_instr(6'h2b, 6'h00, 2, 1, "sw");

    // Reset lands while a store is stalled in its memory cycle.
    opcode = 6'h2b;
    func = 6'h00;
    build(6'h2b, 6'h00, 0, 5);
    run(4, "sw_mid");
    reset_pulse("sw_mid");

    // Five retirements: the 2-bit counter must wrap to 1.
    do_instr(6'h00, 6'h22, 0, 0, "wrap_sub");
    do_instr(6'h0d, 6'h00, 1, 0, "wrap_ori");
    do_instr(6'h02, 6'h00, 0, 0, "wrap_j");
    do_instr(6'h00, 6'h08, 0, 0, "wrap_jr");
    do_instr(6'h2b, 6'h00, 0, 2, "wrap_sw");

    // Reset in the same cycle as a write-back/done.
    opcode = 6'h00;
    func = 6'h20;
    build(6'h00, 6'h20, 0, 0);
    run(3, "done_rst");
    reset_pulse("done_rst");

    for (int n = 0; n < 60; n++) begin
      int k = int'($urandom_range(0, 12));
      if (k == 12) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[k];
      end
      fn = (op == 6'h00 && $urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      do_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $sformatf("rnd%0d_op%02h", n, op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
